// File: rtl/stream_checker_pkg.sv
// Shared types and constants for the stream checker: FSM state encoding
// and the width/saturation value of the 16-bit status counters.
package stream_checker_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sc_fifo.sv
// Expected-value buffer for stream_checker: DEPTH-entry FIFO with a
// registered write and a combinational head read. Pointers carry one extra
// bit so that full and empty are told apart when the address bits match.
// The caller must not push when full or pop when empty.
module sc_fifo
  import stream_checker_pkg::*;
#(
  parameter int NB    = 11,
  parameter int DEPTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic signed [NB-1:0] wdata,
  output logic signed [NB-1:0] rdata,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = $clog2(DEPTH);

  logic signed [NB-1:0] mem [DEPTH];
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Storage write: data only, never reset.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Pointer update: wraps modulo 2*DEPTH; reset empties the FIFO.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/stream_checker.sv
// Stream checker: buffers expected samples in sc_fifo, pops one per valid
// filter output and compares them bit-for-bit, with a one-cycle compare
// latency. Tracks error/sample counts, sticky underrun/overflow flags and a
// completion state after NSAMPLES compares.
// Optional build macro STREAM_CHECKER_FIRST_ERR_EN enables capture of the
// sample index of the first error into FIRST_ERR_IDX (tied to 0 otherwise).
module stream_checker #(
  parameter int NB       = 11,
  parameter int DEPTH    = 8,
  parameter int NSAMPLES = 1024
) (
  input  logic                                  CLK,
  input  logic                                  RST_n,
  input  logic signed [NB-1:0]                  DOUT,
  input  logic                                  VOUT,
  input  logic signed [NB-1:0]                  EXP,
  input  logic                                  VEXP,
  output logic                                  EXP_RDY,
  output logic                                  ERR,
  output logic [stream_checker_pkg::CNT_W-1:0]  ERR_CNT,
  output logic [stream_checker_pkg::CNT_W-1:0]  SMP_CNT,
  output logic                                  UNDERRUN,
  output logic                                  OVERFLOW,
  output logic                                  DONE,
  output logic [stream_checker_pkg::CNT_W-1:0]  FIRST_ERR_IDX
);

  import stream_checker_pkg::*;

  localparam logic [CNT_W-1:0] NSAMP_C = CNT_W'(NSAMPLES);

  // Saturating increment for the error counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + 1'b1;
  endfunction

  state_t               state, state_nxt;
  logic                 active;
  logic                 done_st;
  logic                 full, empty;
  logic signed [NB-1:0] head;
  logic                 pop_req, pop, push, underrun, ovf_evt, mismatch;
  logic                 smp_last;
  logic [CNT_W-1:0]     smp_inc;
  logic                 err_p1;
  logic [CNT_W-1:0]     err_cnt_p1;
  logic [CNT_W-1:0]     smp_cnt_p1;
  logic                 underrun_p1;
  logic                 overflow_p1;

  sc_fifo #(
    .NB    (NB),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST_n (RST_n),
    .push  (push),
    .pop   (pop),
    .wdata (EXP),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Stage p0: request decode and compare against the FIFO head. No bypass,
  // so a pop on an empty FIFO is an underrun even if EXP arrives now.
  assign pop_req  = VOUT & active;
  assign underrun = pop_req & empty;
  assign pop      = pop_req & ~empty;
  assign push     = VEXP & active & ~full;
  assign ovf_evt  = VEXP & active & full;
  assign mismatch = pop_req & (empty | (head != DOUT));
  assign smp_inc  = smp_cnt_p1 + 1'b1;
  assign smp_last = pop_req & (smp_inc == NSAMP_C);
  assign EXP_RDY  = ~full;

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= stream_checker_pkg::IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: DONE is only left through reset.
  always_comb begin
    state_nxt = state;
    case (state)
      stream_checker_pkg::IDLE:
        if (VOUT) state_nxt = smp_last ? stream_checker_pkg::DONE : stream_checker_pkg::RUN;
      stream_checker_pkg::RUN:
        if (smp_last) state_nxt = stream_checker_pkg::DONE;
      default:
        state_nxt = state;
    endcase
  end

  // FSM outputs: compares are live in IDLE and RUN only.
  always_comb begin
    active  = 1'b1;
    done_st = 1'b0;
    if (state == stream_checker_pkg::DONE) begin
      active  = 1'b0;
      done_st = 1'b1;
    end
  end

  // Stage p1: registered compare result, counters and sticky flags.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      err_p1      <= 1'b0;
      err_cnt_p1  <= '0;
      smp_cnt_p1  <= '0;
      underrun_p1 <= 1'b0;
      overflow_p1 <= 1'b0;
    end else begin
      err_p1 <= mismatch;
      if (mismatch) err_cnt_p1 <= sat_inc(err_cnt_p1);
      if (pop_req && (smp_cnt_p1 != NSAMP_C)) smp_cnt_p1 <= smp_inc;
      if (underrun) underrun_p1 <= 1'b1;
      if (ovf_evt)  overflow_p1 <= 1'b1;
    end
  end

  assign ERR      = err_p1;
  assign ERR_CNT  = err_cnt_p1;
  assign SMP_CNT  = smp_cnt_p1;
  assign UNDERRUN = underrun_p1;
  assign OVERFLOW = overflow_p1;
  assign DONE     = done_st;

`ifdef STREAM_CHECKER_FIRST_ERR_EN
  logic             first_seen_p1;
  logic [CNT_W-1:0] first_idx_p1;

  // First-error capture: sample index before increment, held until reset.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      first_seen_p1 <= 1'b0;
      first_idx_p1  <= '0;
    end else if (mismatch && !first_seen_p1) begin
      first_seen_p1 <= 1'b1;
      first_idx_p1  <= smp_cnt_p1;
    end
  end

  assign FIRST_ERR_IDX = first_idx_p1;
`else
  assign FIRST_ERR_IDX = '0;
`endif

endmodule

// File: tb/tb_stream_checker.sv
// Bench for stream_checker: directed scenarios plus randomized traffic,
// checked against a queue-based reference model. A second instance with
// NSAMPLES=4 shares the stimulus and is checked for completion behaviour.
module tb_stream_checker;

  localparam int NB    = 11;
  localparam int DEPTH = 8;
  localparam int NS    = 1024;
  localparam int NS4   = 4;

  logic                 CLK = 1'b0;
  logic                 RST_n = 1'b0;
  logic signed [NB-1:0] dout = '0;
  logic signed [NB-1:0] exp_d = '0;
  logic                 vout = 1'b0;
  logic                 vexp = 1'b0;

  logic        exp_rdy, err, underrun, overflow, done;
  logic [15:0] err_cnt, smp_cnt, first_idx;
  logic        exp_rdy4, err4, underrun4, overflow4, done4;
  logic [15:0] err_cnt4, smp_cnt4, first_idx4;

  stream_checker #(.NB(NB), .DEPTH(DEPTH), .NSAMPLES(NS)) dut (
    .CLK(CLK), .RST_n(RST_n), .DOUT(dout), .VOUT(vout), .EXP(exp_d), .VEXP(vexp),
    .EXP_RDY(exp_rdy), .ERR(err), .ERR_CNT(err_cnt), .SMP_CNT(smp_cnt),
    .UNDERRUN(underrun), .OVERFLOW(overflow), .DONE(done), .FIRST_ERR_IDX(first_idx)
  );

  stream_checker #(.NB(NB), .DEPTH(DEPTH), .NSAMPLES(NS4)) dut4 (
    .CLK(CLK), .RST_n(RST_n), .DOUT(dout), .VOUT(vout), .EXP(exp_d), .VEXP(vexp),
    .EXP_RDY(exp_rdy4), .ERR(err4), .ERR_CNT(err_cnt4), .SMP_CNT(smp_cnt4),
    .UNDERRUN(underrun4), .OVERFLOW(overflow4), .DONE(done4), .FIRST_ERR_IDX(first_idx4)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, expv);
    end
  endtask

  // Reference model: expected values in a queue, counters as plain integers.
  int q[$];
  int m_err_cnt, m_smp, m_first;
  bit m_err, m_under, m_over, m_done, m_first_seen;

  task automatic model_reset();
    q.delete();
    m_err_cnt = 0; m_smp = 0; m_first = 0;
    m_err = 0; m_under = 0; m_over = 0; m_done = 0; m_first_seen = 0;
  endtask

  task automatic model_step(input bit vo, input int d, input bit ve, input int e);
    int n0;
    bit bad;
    n0    = q.size();
    bad   = 0;
    m_err = 0;
    if (!m_done) begin
      if (vo) begin
        if (n0 == 0) begin
          bad = 1;
          m_under = 1;
        end else if (q.pop_front() != d) begin
          bad = 1;
        end
        if (bad) begin
          m_err = 1;
          if (!m_first_seen) begin
            m_first_seen = 1;
            m_first = m_smp;
          end
          if (m_err_cnt < 65535) m_err_cnt++;
        end
        if (m_smp < NS) m_smp++;
        if (m_smp == NS) m_done = 1;
      end
      if (ve) begin
        if (n0 >= DEPTH) m_over = 1;
        else q.push_back(e);
      end
    end
  endtask

  function automatic int exp_first();
`ifdef STREAM_CHECKER_FIRST_ERR_EN
    return m_first;
`else
    return 0;
`endif
  endfunction

  task automatic check_main();
    check("ERR",       {31'd0, err},      {31'd0, m_err});
    check("ERR_CNT",   {16'd0, err_cnt},  m_err_cnt);
    check("SMP_CNT",   {16'd0, smp_cnt},  m_smp);
    check("UNDERRUN",  {31'd0, underrun}, {31'd0, m_under});
    check("OVERFLOW",  {31'd0, overflow}, {31'd0, m_over});
    check("EXP_RDY",   {31'd0, exp_rdy},  (q.size() < DEPTH) ? 1 : 0);
    check("DONE",      {31'd0, done},     {31'd0, m_done});
    check("FIRST_IDX", {16'd0, first_idx}, exp_first());
  endtask

  // One clock: drive at edge+1, step the model, sample at next edge+1.
  task automatic cycle(input bit vo, input int d, input bit ve, input int e);
    vout  = vo;
    dout  = NB'(d);
    vexp  = ve;
    exp_d = NB'(e);
    model_step(vo, d, ve, e);
    @(posedge CLK);
    #1;
    vout = 1'b0;
    vexp = 1'b0;
    check_main();
  endtask

  task automatic do_reset();
    vout = 1'b0;
    vexp = 1'b0;
    RST_n = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
    RST_n = 1'b1;
    check_main();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    bit vo, ve;
    model_reset();
    #3;
    check("RST_ERR_CNT", {16'd0, err_cnt}, 0);
    check("RST_EXP_RDY", {31'd0, exp_rdy}, 1);
    check_main();
    @(posedge CLK);
    #1;
    RST_n = 1'b1;

    // Push 1..8, then matching outputs 1..8.
    for (int i = 1; i <= 8; i++) cycle(0, 0, 1, i);
    check("FULL_EXP_RDY", {31'd0, exp_rdy}, 0);
    for (int i = 1; i <= 8; i++) cycle(1, i, 0, 0);
    check("MATCH8_ERR_CNT", {16'd0, err_cnt}, 0);
    check("MATCH8_SMP_CNT", {16'd0, smp_cnt}, 8);

    // Single mismatch on the second sample.
    do_reset();
    cycle(0, 0, 1, 5); cycle(0, 0, 1, 6); cycle(0, 0, 1, 7);
    cycle(1, 5, 0, 0);
    check("MM_ERR_AFTER1", {31'd0, err}, 0);
    cycle(1, 9, 0, 0);
    check("MM_ERR_AFTER2", {31'd0, err}, 1);
    cycle(1, 7, 0, 0);
    check("MM_ERR_AFTER3", {31'd0, err}, 0);
    check("MM_ERR_CNT", {16'd0, err_cnt}, 1);
`ifdef STREAM_CHECKER_FIRST_ERR_EN
    check("MM_FIRST_IDX", {16'd0, first_idx}, 1);
`else
    check("MM_FIRST_IDX", {16'd0, first_idx}, 0);
`endif

    // Underrun with a simultaneous push: no bypass, entry stays buffered.
    do_reset();
    cycle(1, 3, 1, 3);
    check("UR_UNDERRUN", {31'd0, underrun}, 1);
    check("UR_ERR_CNT", {16'd0, err_cnt}, 1);
    cycle(1, 3, 0, 0);
    check("UR_HELD_ERR", {31'd0, err}, 0);

    // Overflow: value pushed while full is dropped.
    do_reset();
    for (int i = 1; i <= 8; i++) cycle(0, 0, 1, 20 + i);
    cycle(0, 0, 1, 100);
    check("OV_OVERFLOW", {31'd0, overflow}, 1);
    cycle(1, 21, 1, 100);
    for (int i = 2; i <= 8; i++) cycle(1, 20 + i, 0, 0);
    cycle(1, 100, 0, 0);
    check("OV_100_DROPPED_UR", {31'd0, underrun}, 1);

    // Mid-stream asynchronous reset with 3 entries and 2 errors.
    do_reset();
    for (int i = 1; i <= 5; i++) cycle(0, 0, 1, i);
    cycle(1, 50, 0, 0);
    cycle(1, 51, 0, 0);
    check("PRE_RST_ERR_CNT", {16'd0, err_cnt}, 2);
    #2;
    RST_n = 1'b0;
    #1;
    model_reset();
    check("ARST_ERR_CNT",  {16'd0, err_cnt},  0);
    check("ARST_SMP_CNT",  {16'd0, smp_cnt},  0);
    check("ARST_ERR",      {31'd0, err},      0);
    check("ARST_DONE",     {31'd0, done},     0);
    check("ARST_FLAGS",    {30'd0, underrun, overflow}, 0);
    check("ARST_FIRST",    {16'd0, first_idx}, 0);
    check("ARST_EXP_RDY",  {31'd0, exp_rdy},  1);
    @(posedge CLK);
    #1;
    RST_n = 1'b1;
    cycle(1, 3, 0, 0);
    check("POST_RST_UNDERRUN", {31'd0, underrun}, 1);

    // Completion on the NSAMPLES=4 instance.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 10 + i);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 10 + i, 0, 0);
      check("D4_DONE", {31'd0, done4}, (i == 3) ? 1 : 0);
    end
    check("D4_SMP_CNT", {16'd0, smp_cnt4}, 4);
    cycle(1, 99, 1, 7);
    check("D4_SMP_HOLD", {16'd0, smp_cnt4}, 4);
    check("D4_ERR_ZERO", {31'd0, err4}, 0);
    check("D4_ERR_CNT", {16'd0, err_cnt4}, 0);
    cycle(0, 0, 0, 0);
    check("D4_DONE_HELD", {31'd0, done4}, 1);

    // Randomized traffic with varying push/pop bias and one mid-run reset.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      case ((i / 250) % 3)
        0:       begin vo = ($urandom_range(0, 3) == 0); ve = ($urandom_range(0, 3) != 0); end
        1:       begin vo = ($urandom_range(0, 3) != 0); ve = ($urandom_range(0, 3) == 0); end
        default: begin vo = $urandom_range(0, 1) == 1;   ve = $urandom_range(0, 1) == 1;   end
      endcase
      if (q.size() > 0 && $urandom_range(0, 7) != 0) d = q[0];
      else d = int'($urandom_range(0, 2047)) - 1024;
      cycle(vo, d, ve, int'($urandom_range(0, 2047)) - 1024);
      if (i == 700) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
